// File: rtl/clk_div_reset_gen.sv
// Multi-channel clock divider with per-channel reloadable divisor, period-aligned
// enable, single-cycle tick, plus a stretched downstream reset and lock flag.
module clk_div_reset_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int RESET_HOLD  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS*DIV_WIDTH-1:0] div_i,
    input  logic [CHANNELS-1:0]           div_load_i,
    input  logic [CHANNELS-1:0]           enable_i,
    output logic [CHANNELS-1:0]           clk_o,
    output logic [CHANNELS-1:0]           tick_o,
    output logic                          soc_reset_o,
    output logic                          locked_o
);

    localparam int HW = $clog2(RESET_HOLD + 1);

    logic [CHANNELS-1:0] pend_next;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d, pdiv_eff;
        logic                 pend_q, pend_d, run_q, run_d, clk_q, clk_d, tick_q, tick_d;
        logic                 pend_eff, active, boundary;
        logic [DIV_WIDTH:0]   half;

        always_comb begin
            // A load in the boundary cycle bypasses pend_div and lands at that boundary
            pend_eff = pend_q | div_load_i[g];
            pdiv_eff = div_load_i[g] ? div_i[g*DIV_WIDTH +: DIV_WIDTH] : pdiv_q;
            active   = run_q && (div_q != '0);
            boundary = active && (cnt_q == div_q - 1'b1);
            cnt_d    = cnt_q;
            div_d    = div_q;
            pdiv_d   = pdiv_eff;
            pend_d   = pend_eff;
            run_d    = run_q;
            if (!active) begin
                cnt_d = '0;
                if (pend_eff) begin
                    div_d  = pdiv_eff;
                    pend_d = 1'b0;
                end
                if (!run_q && enable_i[g]) run_d = 1'b1;
            end else if (boundary) begin
                cnt_d = '0;
                if (pend_eff) begin
                    div_d  = pdiv_eff;
                    pend_d = 1'b0;
                end
                if (!enable_i[g]) run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // One extra bit keeps N+1 from wrapping at the maximum divisor
            half   = ({1'b0, div_d} + 1'b1) >> 1;
            clk_d  = run_d && (div_d != '0) && ({1'b0, cnt_d} >= half);
            tick_d = run_d && (div_d != '0) && (cnt_d == div_d - 1'b1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                div_q  <= DIV_WIDTH'(DEFAULT_DIV);
                pdiv_q <= DIV_WIDTH'(DEFAULT_DIV);
                pend_q <= 1'b0;
                run_q  <= 1'b1;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                run_q  <= run_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_o[g]     = clk_q;
        assign tick_o[g]    = tick_q;
        assign pend_next[g] = pend_d;
    end

    logic [HW-1:0] hold_q, hold_d;
    logic          soc_q, soc_d, lock_q, lock_d;

    always_comb begin
        hold_d = (hold_q == HW'(RESET_HOLD)) ? hold_q : hold_q + 1'b1;
        soc_d  = (hold_d != HW'(RESET_HOLD));
        lock_d = ~soc_d & ~|pend_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            soc_q  <= 1'b1;
            lock_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            soc_q  <= soc_d;
            lock_q <= lock_d;
        end
    end

    assign soc_reset_o = soc_q;
    assign locked_o    = lock_q;

endmodule

// File: tb/tb_clk_div_reset_gen.sv
// Directed bench for clk_div_reset_gen: expectations are queued before each clock
// edge and checked against the registered outputs on the following falling edge.
module tb_clk_div_reset_gen;

    localparam int CH = 2;
    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [CH*DW-1:0]   div_i;
    logic [CH-1:0]      div_load_i;
    logic [CH-1:0]      enable_i;
    logic [CH-1:0]      clk_o;
    logic [CH-1:0]      tick_o;
    logic               soc_reset_o;
    logic               locked_o;

    clk_div_reset_gen #(
        .CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(2), .RESET_HOLD(16)
    ) dut (
        .clk(clk), .reset(reset), .div_i(div_i), .div_load_i(div_load_i),
        .enable_i(enable_i), .clk_o(clk_o), .tick_o(tick_o),
        .soc_reset_o(soc_reset_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sel;
        int    ch;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic obs(input int sel, input int ch);
        case (sel)
            0:       return clk_o[ch];
            1:       return tick_o[ch];
            2:       return soc_reset_o;
            default: return locked_o;
        endcase
    endfunction

    task automatic check(input string tag, input logic o, input logic e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input int sel, input int ch, input logic e);
        exp_t x;
        x.tag = tag; x.sel = sel; x.ch = ch; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic exp_ch(input string tag, input int ch, input logic c, input logic t);
        push({tag, " clk"}, 0, ch, c);
        push({tag, " tick"}, 1, ch, t);
    endtask

    task automatic exp_sys(input string tag, input logic sr, input logic lk);
        push({tag, " soc_reset"}, 2, 0, sr);
        push({tag, " locked"}, 3, 0, lk);
    endtask

    // Advance one rising edge, then drain the scoreboard on the falling edge
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sel, e.ch), e.exp);
        end
    endtask

    task automatic load(input int ch, input int v);
        div_i[ch*DW +: DW] = DW'(v);
        div_load_i[ch]     = 1'b1;
    endtask

    // Expected waveform over `cycles` edges: cnt after each edge starts at c0
    task automatic wave(input int ch, input int n, input int c0, input int cycles, input logic lk);
        int c = c0;
        for (int i = 0; i < cycles; i++) begin
            exp_ch($sformatf("wave ch%0d N%0d cnt%0d", ch, n, c), ch, c >= (n + 1) / 2, c == n - 1);
            push($sformatf("wave ch%0d N%0d locked", ch, n), 3, 0, lk);
            cyc();
            c = (c + 1) % n;
        end
    endtask

    // Default divide-by-2 on both channels and the 16-cycle reset stretch
    task automatic post_reset(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            exp_ch($sformatf("%s ch0 k%0d", tag, k), 0, k[0], k[0]);
            exp_ch($sformatf("%s ch1 k%0d", tag, k), 1, k[0], k[0]);
            exp_sys($sformatf("%s k%0d", tag, k), k < 16, k >= 16);
            cyc();
        end
    endtask

    initial begin
        reset      = 1'b1;
        div_i      = '0;
        div_load_i = '0;
        enable_i   = '1;

        for (int i = 0; i < 2; i++) begin
            exp_ch("reset ch0", 0, 1'b0, 1'b0);
            exp_ch("reset ch1", 1, 1'b0, 1'b0);
            exp_sys("reset", 1'b1, 1'b0);
            cyc();
        end
        reset = 1'b0;
        post_reset("default", 20);

        // Odd divisor loaded mid-period: old period finishes first
        load(1, 5);
        exp_ch("load5 old period", 1, 1'b1, 1'b1);
        push("load5 pending locked", 3, 0, 1'b0);
        cyc();
        div_load_i = '0;
        wave(1, 5, 0, 10, 1'b1);

        // Back-to-back loads 3 then 7: only 7 survives
        wave(1, 5, 0, 1, 1'b1);
        load(1, 3);
        exp_ch("load3 cnt1", 1, 1'b0, 1'b0);
        push("load3 locked", 3, 0, 1'b0);
        cyc();
        load(1, 7);
        exp_ch("load7 cnt2", 1, 1'b0, 1'b0);
        push("load7 locked", 3, 0, 1'b0);
        cyc();
        div_load_i = '0;
        exp_ch("pend cnt3", 1, 1'b1, 1'b0);
        push("pend cnt3 locked", 3, 0, 1'b0);
        cyc();
        exp_ch("pend cnt4", 1, 1'b1, 1'b1);
        push("pend cnt4 locked", 3, 0, 1'b0);
        cyc();
        wave(1, 7, 0, 7, 1'b1);
        // Load coincident with the boundary applies at that boundary
        load(1, 3);
        exp_ch("coincident load3", 1, 1'b0, 1'b0);
        push("coincident locked", 3, 0, 1'b1);
        cyc();
        div_load_i = '0;
        wave(1, 3, 1, 5, 1'b1);

        // Reset while an update to 6 is pending
        wave(1, 3, 0, 1, 1'b1);
        load(1, 6);
        exp_ch("load6 cnt1", 1, 1'b0, 1'b0);
        push("load6 locked", 3, 0, 1'b0);
        cyc();
        div_load_i = '0;
        reset      = 1'b1;
        exp_ch("midreset ch0", 0, 1'b0, 1'b0);
        exp_ch("midreset ch1", 1, 1'b0, 1'b0);
        exp_sys("midreset", 1'b1, 1'b0);
        cyc();
        reset = 1'b0;
        post_reset("after midreset", 18);

        // Halt with N=0, then N=1, then N=255
        load(0, 0);
        exp_ch("load0 old period", 0, 1'b1, 1'b1);
        push("load0 locked", 3, 0, 1'b0);
        cyc();
        div_load_i = '0;
        for (int i = 0; i < 5; i++) begin
            exp_ch($sformatf("halted %0d", i), 0, 1'b0, 1'b0);
            push("halted locked", 3, 0, 1'b1);
            cyc();
        end
        load(0, 1);
        exp_ch("load1 from halt", 0, 1'b0, 1'b1);
        push("load1 locked", 3, 0, 1'b1);
        cyc();
        div_load_i = '0;
        for (int i = 0; i < 4; i++) begin
            exp_ch($sformatf("N1 %0d", i), 0, 1'b0, 1'b1);
            cyc();
        end
        load(0, 255);
        exp_ch("load255", 0, 1'b0, 1'b0);
        cyc();
        div_load_i = '0;
        wave(0, 255, 1, 254, 1'b1);
        load(0, 4);
        exp_ch("load4 at N255 boundary", 0, 1'b0, 1'b0);
        cyc();
        div_load_i = '0;

        // Enable: drop at cnt1, period completes, then flat
        wave(0, 4, 1, 1, 1'b1);
        enable_i[0] = 1'b0;
        exp_ch("disable cnt2", 0, 1'b1, 1'b0);
        cyc();
        exp_ch("disable cnt3", 0, 1'b1, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            exp_ch($sformatf("stopped %0d", i), 0, 1'b0, 1'b0);
            push("stopped locked", 3, 0, 1'b1);
            cyc();
        end
        enable_i[0] = 1'b1;
        exp_ch("restart cnt0", 0, 1'b0, 1'b0);
        cyc();
        wave(0, 4, 1, 4, 1'b1);
        // Short disable pulse inside a period has no effect
        enable_i[0] = 1'b0;
        wave(0, 4, 1, 1, 1'b1);
        enable_i[0] = 1'b1;
        wave(0, 4, 2, 1, 1'b1);
        wave(0, 4, 3, 6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_reset_gen.md
Name: clk_div_reset_gen

Overview:
Parametrised clock-enable and divided-clock generator with a reset stretcher, placed in FPGA top levels between the single-ended reference clock and the Grande_Risco_5_SOC instances.
- Generalises the fixed divide-by-2 toggle flop to CHANNELS independent channels.
- Each channel has a runtime-reloadable divisor, glitch-free divisor update and enable/disable at period boundaries, and a single-cycle tick output.
- Also produces a stretched SOC reset and a locked indication.
- With CHANNELS=1 and DEFAULT_DIV=2, clk_o[0] matches the legacy divide-by-2 waveform exactly.

Parameters:
CHANNELS, 2, number of independent divider channels
DIV_WIDTH, 8, width of each divisor, full period in clk cycles
DEFAULT_DIV, 2, divisor loaded into every channel at reset
RESET_HOLD, 16, clk cycles soc_reset_o stays high after reset deasserts; legal range is 1 or more

Ports:
clk  input  1  reference clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
div_i  input  CHANNELS*DIV_WIDTH  new divisor; channel k uses bits [k*DIV_WIDTH +: DIV_WIDTH]
div_load_i  input  CHANNELS  one-cycle strobe per channel to capture its div_i slice
enable_i  input  CHANNELS  per-channel run request
clk_o  output  CHANNELS  registered divided clock per channel
tick_o  output  CHANNELS  registered one-cycle pulse in the last cycle of each period
soc_reset_o  output  1  stretched reset for downstream logic
locked_o  output  1  high when out of reset and no divisor update is pending

Behaviour:
Reset (synchronous, active-high; any cycle, including mid-period or mid-update):
- Per channel: cnt=0, div_q=DEFAULT_DIV, pending=0, run=1.
- Outputs: clk_o=0, tick_o=0, soc_reset_o=1, locked_o=0.

Per-channel counter, with N=div_q:
- Counts 0..N-1, then wraps. The cycle where cnt==N-1 is the boundary.
- Registered outputs are computed from the next counter value:
  - clk_o <= (cnt_next >= ceil(N/2)), so the output is low first, then high.
  - tick_o <= (cnt_next == N-1).
- N=2: 0,1,0,1... starting at 0 in the first cycle after reset.
- N=3: low 2 cycles, high 1 cycle.
- N=1: cnt stays 0, clk_o=0, tick_o=1 every cycle.
- N=0: channel halted; cnt=0, clk_o=0, tick_o=0.

Divisor update:
- div_load_i[k] captures the slice into pend_div and sets pending.
- Multiple loads before a boundary: the last one wins.
- Applied at the boundary: div_q<=pend_div, cnt<=0, pending cleared. The new period starts the next cycle.
- Load in the same cycle as a boundary: bypass, so the loaded value is applied at that boundary.
- Load while the channel is halted (N=0) or stopped: applied on the next cycle.
- No truncated or extended period is ever emitted for the old divisor.

Enable:
- enable_i[k]=0 takes effect at the next boundary: the current period completes, then run=0 with cnt=0, clk_o=0, tick_o=0.
- While stopped, enable_i=1 restarts counting on the next cycle with cnt=0.
- Deassert and reassert before the boundary: no effect.

Reset stretcher and lock:
- A hold counter runs after reset deasserts. soc_reset_o falls exactly RESET_HOLD cycles after the first cycle with reset=0.
- locked_o <= ~soc_reset_o_next & ~|pending_next.

Width and misc:
- Counters are DIV_WIDTH bits.
- ceil(N/2) is computed as (N+1)>>1 in DIV_WIDTH+1 bits to avoid overflow at N=2^DIV_WIDTH-1.
- No combinational path from any input to any output.

Test Plan:
- Default run (CHANNELS=1, DEFAULT_DIV=2): release reset → clk_o = 0,1,0,1 and tick_o high on every clk_o=1 cycle; soc_reset_o falls exactly 16 cycles after reset deasserts; locked_o rises with it.
- Odd divisor: load 5 on channel 1 mid-period → old period completes intact, then clk_o1 low 3 cycles / high 2, tick_o1 once per 5 cycles; locked_o low from load until the boundary.
- Back-to-back loads 3 then 7 before a boundary, and a load coincident with a boundary → only 7 is applied; the coincident load takes effect at that same boundary.
- Halt and edge divisors: load 0 → channel 0 outputs flat 0; load 1 → tick_o0 constant 1, clk_o0=0; load 255 → high 127 / low 128 with no overflow.
- Enable: deassert enable_i0 at cnt=1 of N=4 → cycles cnt=2,3 still produced, then flat 0; reassert → a full period starts the next cycle; a deassert/reassert pulse inside a period → no disturbance.
- Reset mid-operation: assert reset during a pending update with N=6 → all outputs return to reset values next cycle, divisor reverts to DEFAULT_DIV, pending is dropped.
